// File: rtl/hamming74_pkg.sv
// rtl/hamming74_pkg.sv - Hamming(7,4) code layout, syndrome helper and receiver FSM encoding
package hamming74_pkg;

   localparam int P1_IDX = 0;
   localparam int P2_IDX = 1;
   localparam int D0_IDX = 2;
   localparam int P4_IDX = 3;
   localparam int D1_IDX = 4;
   localparam int D2_IDX = 5;
   localparam int D3_IDX = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_DONE  = 3'd4
   } rx_state_e;

   // Syndrome value equals the 1-based position of a single flipped bit.
   function automatic logic [2:0] syndrome74(input logic [6:0] c);
      logic s1, s2, s4;
      s1 = c[P1_IDX] ^ c[D0_IDX] ^ c[D1_IDX] ^ c[D3_IDX];
      s2 = c[P2_IDX] ^ c[D0_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
      s4 = c[P4_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
      return {s4, s2, s1};
   endfunction

endpackage

// File: rtl/hamming_decoder_74.sv
// rtl/hamming_decoder_74.sv - combinational Hamming(7,4) single-error-correcting decoder
module hamming_decoder_74
   import hamming74_pkg::*;
(
   input  logic [6:0] code,
   output logic [3:0] data,
   output logic [2:0] syndrome,
   output logic       corrected
);

   logic [6:0] fixed;

   always_comb begin
      syndrome = syndrome74(code);
      fixed    = code;
      for (int i = 0; i < 7; i++) begin
         if (syndrome == 3'(i + 1)) fixed[i] = ~code[i];
      end
      data      = {fixed[D3_IDX], fixed[D2_IDX], fixed[D1_IDX], fixed[D0_IDX]};
      corrected = |syndrome;
   end

endmodule

// File: rtl/uart_hamming_receiver.sv
// rtl/uart_hamming_receiver.sv - 8N1 UART deserialiser feeding a Hamming(7,4) decoder
module uart_hamming_receiver
   import hamming74_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [3:0] data_out,
   output logic       valid,
   output logic       corrected,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_e        state_q, state_d;
   logic             rx_m_q, rx_s_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sh_q, sh_d;
   logic             stop_q, stop_d;
   logic [3:0]       data_out_q, data_out_d;
   logic             valid_q, valid_d;
   logic             corrected_q, corrected_d;
   logic             frame_err_q, frame_err_d;

   logic [3:0]       dec_data;
   logic [2:0]       dec_syndrome;
   logic             dec_corrected;

   hamming_decoder_74 u_dec (
      .code      (sh_q[6:0]),
      .data      (dec_data),
      .syndrome  (dec_syndrome),
      .corrected (dec_corrected)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         stop_q      <= 1'b0;
         data_out_q  <= '0;
         valid_q     <= 1'b0;
         corrected_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_m_q      <= rx;
         rx_s_q      <= rx_m_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         stop_q      <= stop_d;
         data_out_q  <= data_out_d;
         valid_q     <= valid_d;
         corrected_q <= corrected_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      stop_d  = stop_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s_q, sh_q[7:1]};
               if (idx_q == 3'd7) state_d = ST_STOP;
               else               idx_d   = idx_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               stop_d  = rx_s_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bad frames leave data_out/corrected untouched so the last good nibble stays visible.
   always_comb begin
      data_out_d  = data_out_q;
      corrected_d = corrected_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      if (state_q == ST_DONE) begin
         if (stop_q && !sh_q[7]) begin
            valid_d     = 1'b1;
            data_out_d  = dec_data;
            corrected_d = dec_corrected;
         end else begin
            frame_err_d = 1'b1;
         end
      end
   end

   assign data_out  = data_out_q;
   assign valid     = valid_q;
   assign corrected = corrected_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = (state_q != ST_IDLE);

endmodule
